// File: rtl/dotproduct_stream.sv
// -----------------------------------------------------------------------------
// dotproduct_stream
//
// Streaming, pipelined signed dot-product engine. Vectors arrive as a sequence
// of N-lane beats over a valid/ready handshake. Each beat's lane products are
// reduced in stage S1. Stage S2 accumulates the beat sums and emits one result
// per vector, together with its beat count.
//
// Optional feature macro: DOTPRODUCT_SAT_EN
//   defined   : the accumulator saturates. Any clamp raises the sticky ovf flag
//               for that vector.
//   undefined : the accumulator wraps modulo 2^ACC_WIDTH, and ovf stays 0.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   beat offered
//   in_ready   out  beat can be accepted this cycle
//   in_last    in   offered beat closes its vector
//   x, w       in   packed signed operands/weights, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  result held on dp/beats/ovf
//   out_ready  in   consumer accepts result
//   dp         out  signed dot product of the completed vector
//   beats      out  beats in that vector (saturating)
//   ovf        out  accumulator saturated during that vector
// -----------------------------------------------------------------------------
module dotproduct_stream #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [N*DATA_WIDTH-1:0]   x,
    input  logic [N*DATA_WIDTH-1:0]   w,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH-1:0]      dp,
    output logic [CNT_WIDTH-1:0]      beats,
    output logic                      ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    // ---------------------------------------------------------------- S1 reduce
    // Each lane operand is widened to full product precision before the
    // multiply, so every product is exact.
    logic signed [PW-1:0]        prod [N];
    logic signed [ACC_WIDTH-1:0] part_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic signed [PW-1:0] xs;
            logic signed [PW-1:0] ws;
            assign xs = PW'($signed(x[gi*DATA_WIDTH +: DATA_WIDTH]));
            assign ws = PW'($signed(w[gi*DATA_WIDTH +: DATA_WIDTH]));
            assign prod[gi] = xs * ws;
        end
    endgenerate

    // The width requirement on ACC_WIDTH keeps this adder tree exact.
    always_comb begin
        part_next = '0;
        for (int i = 0; i < N; i++) begin
            part_next = part_next + ACC_WIDTH'(prod[i]);
        end
    end

    logic                        s1_valid_reg;
    logic                        s1_last_reg;
    logic signed [ACC_WIDTH-1:0] part_reg;

    // ------------------------------------------------------------ S2 accumulate
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic [CNT_WIDTH-1:0]        cnt_reg;
    logic                        first_reg;
    logic                        sticky_reg;
    logic                        out_valid_reg;
    logic [ACC_WIDTH-1:0]        dp_reg;
    logic [CNT_WIDTH-1:0]        beats_reg;
    logic                        ovf_reg;

    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic [CNT_WIDTH-1:0]        cnt_base;
    logic [CNT_WIDTH-1:0]        cnt_next;
    logic                        clamp;
    logic                        sticky_next;
    logic                        stall;

    // The first beat of a vector starts from zero instead of the stale accumulator.
    assign base     = first_reg ? '0 : acc_reg;
    assign cnt_base = first_reg ? '0 : cnt_reg;
    assign cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);

`ifdef DOTPRODUCT_SAT_EN
    // One extra bit of headroom exposes signed overflow as a mismatch of the two MSBs.
    logic signed [ACC_WIDTH:0] sum_wide;
    assign sum_wide = {base[ACC_WIDTH-1], base} + {part_reg[ACC_WIDTH-1], part_reg};
    assign clamp    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    always_comb begin
        sum_next = sum_wide[ACC_WIDTH-1:0];
        if (clamp) begin
            // A negative overflow clamps to the minimum, a positive one to the maximum.
            sum_next = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_next = base + part_reg;
    assign clamp    = 1'b0;
`endif

    assign sticky_next = (first_reg ? 1'b0 : sticky_reg) | clamp;

    // A finished vector waiting in S1 cannot move into a result slot that is
    // still occupied, so the whole pipe freezes.
    assign stall    = s1_valid_reg && s1_last_reg && out_valid_reg && !out_ready;
    assign in_ready = !rst && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            part_reg      <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            first_reg     <= 1'b1;
            sticky_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            dp_reg        <= '0;
            beats_reg     <= '0;
            ovf_reg       <= 1'b0;
        end else if (!stall) begin
            // S1: in_ready is high in this branch, so in_valid alone means accept.
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_last_reg <= in_last;
                part_reg    <= part_next;
            end

            // A consume clears the output, but a load later in this block overrides the clear.
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            // S2
            if (s1_valid_reg) begin
                if (s1_last_reg) begin
                    dp_reg        <= sum_next;
                    beats_reg     <= cnt_next;
                    ovf_reg       <= sticky_next;
                    out_valid_reg <= 1'b1;
                    first_reg     <= 1'b1;
                end else begin
                    acc_reg    <= sum_next;
                    first_reg  <= 1'b0;
                end
                cnt_reg    <= cnt_next;
                sticky_reg <= sticky_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign dp        = dp_reg;
    assign beats     = beats_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_dotproduct_stream.sv
module tb_dotproduct_stream;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 24;
    localparam int CW  = 16;
    localparam longint ACC_MAX = (64'sd1 <<< (AW-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW-1));

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] x = '0;
    logic [N*DW-1:0] w = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [AW-1:0]   dp;
    logic [CW-1:0]   beats;
    logic            ovf;

    dotproduct_stream #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .x(x), .w(w),
        .out_valid(out_valid), .out_ready(out_ready),
        .dp(dp), .beats(beats), .ovf(ovf)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] dp;
        logic [CW-1:0] beats;
        logic          ovf;
    } res_t;

    res_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   rdy_rand = 1'b0;

    // Reference model state, in plain integer arithmetic.
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_first = 1'b1;
    bit     m_sticky = 1'b0;

    function automatic void model_reset();
        m_acc = 0; m_cnt = 0; m_first = 1'b1; m_sticky = 1'b0;
    endfunction

    function automatic void model_beat(input logic [N*DW-1:0] xv, input logic [N*DW-1:0] wv, input bit last);
        longint part, s;
        int a, b, c;
        bit cl;
        logic signed [AW-1:0] t;
        res_t r;
        part = 0;
        for (int i = 0; i < N; i++) begin
            a = $signed(xv[i*DW +: DW]);
            b = $signed(wv[i*DW +: DW]);
            part += longint'(a * b);
        end
        s  = (m_first ? 0 : m_acc) + part;
        cl = 1'b0;
`ifdef DOTPRODUCT_SAT_EN
        if (s > ACC_MAX) begin s = ACC_MAX; cl = 1'b1; end
        if (s < ACC_MIN) begin s = ACC_MIN; cl = 1'b1; end
`else
        t = s[AW-1:0];
        s = t;
`endif
        c = (m_first ? 0 : m_cnt) + 1;
        if (c > 65535) c = 65535;
        m_sticky = (m_first ? 1'b0 : m_sticky) | cl;
        m_cnt = c;
        if (last) begin
            r.dp = s[AW-1:0]; r.beats = c[CW-1:0]; r.ovf = m_sticky;
            sb.push_back(r);
            m_first = 1'b1;
        end else begin
            m_acc = s;
            m_first = 1'b0;
        end
    endfunction

    // Scoreboard monitor: compares each consumed result, sampled on the falling edge.
    initial forever begin
        res_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got dp=%0d beats=%0d ovf=%0b, none expected",
                         $signed(dp), beats, ovf);
            end else begin
                e = sb.pop_front();
                if ({dp, beats, ovf} !== e) begin
                    n_fail++;
                    $display("FAIL result: got dp=%0d beats=%0d ovf=%0b, expected dp=%0d beats=%0d ovf=%0b",
                             $signed(dp), beats, ovf, $signed(e.dp), e.beats, e.ovf);
                end else begin
                    $display("result dp=%0d beats=%0d ovf=%0b ok", $signed(dp), beats, ovf);
                end
            end
        end
    end

    // Random backpressure generator.
    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Offers one beat and returns 1 time unit after the edge that accepted it.
    task automatic send_beat(input logic [N*DW-1:0] xv, input logic [N*DW-1:0] wv, input bit last);
        bit fire;
        in_valid = 1'b1; x = xv; w = wv; in_last = last;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk); #1;
            if (fire) begin
                model_beat(xv, wv, last);
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL accept_timeout: beat not accepted within 1000 cycles, required accept");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int t;
        rdy_rand = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, dp, beats, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out_valid=%b dp=%0d beats=%0d ovf=%b, required all 0", out_valid, dp, beats, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: out_valid=%b after accept edge, required 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || $signed(dp) !== 70 || beats !== 16'd1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: out_valid=%b dp=%0d beats=%0d ovf=%b, required 1/70/1/0", out_valid, $signed(dp), beats, ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: out_valid=%b, required 0", out_valid); end
        drain();
    endtask

    task automatic test_multi_beat();
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            send_beat({4{8'h80}}, {4{8'h80}}, b == 2);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL multi_early: out_valid=%b after beat %0d, required 0", out_valid, b+1); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || $signed(dp) !== 196608 || beats !== 16'd3) begin
            n_fail++;
            $display("FAIL multi_result: out_valid=%b dp=%0d beats=%0d, required 1/196608/3", out_valid, $signed(dp), beats);
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
        send_beat({4{8'hFF}}, {4{8'd2}}, 1'b1);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || $signed(dp) !== 70) begin
            n_fail++;
            $display("FAIL bp_stall: in_ready=%b out_valid=%b dp=%0d, required 0/1/70", in_ready, out_valid, $signed(dp));
        end
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (out_valid !== 1'b1 || $signed(dp) !== 70 || beats !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b dp=%0d beats=%0d, required 1/70/1", out_valid, $signed(dp), beats);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || $signed(dp) !== -8 || beats !== 16'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second: out_valid=%b dp=%0d beats=%0d in_ready=%b, required 1/-8/1/1", out_valid, $signed(dp), beats, in_ready);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        out_ready = 1'b1;
        c0 = $time;
        for (int v = 0; v < 5; v++) send_beat({8'(v), 8'd1, 8'd2, 8'd3}, {8'd2, 8'd2, 8'd2, 8'(-v)}, 1'b1);
        in_valid = 1'b0;
        n_cmp++;
        if (($time - c0) != 50) begin
            n_fail++;
            $display("FAIL b2b_throughput: 5 beats took %0d ns, required 50", $time - c0);
        end
        drain();
    endtask

    task automatic test_saturation();
        longint exp_dp;
        bit exp_ovf;
`ifdef DOTPRODUCT_SAT_EN
        exp_dp = 8388607; exp_ovf = 1'b1;
`else
        exp_dp = -8388608; exp_ovf = 1'b0;
`endif
        out_ready = 1'b1;
        for (int b = 0; b < 128; b++) send_beat({4{8'h80}}, {4{8'h80}}, b == 127);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || longint'($signed(dp)) !== exp_dp || beats !== 16'd128 || ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL saturation: out_valid=%b dp=%0d beats=%0d ovf=%b, required 1/%0d/128/%b",
                     out_valid, $signed(dp), beats, ovf, exp_dp, exp_ovf);
        end
        drain();
    endtask

    task automatic test_reset_mid_vector();
        out_ready = 1'b1;
        send_beat({4{8'd9}}, {4{8'd9}}, 1'b0);
        send_beat({4{8'd9}}, {4{8'd9}}, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, dp, beats, ovf} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: out_valid=%b dp=%0d beats=%0d ovf=%b, required all 0", out_valid, dp, beats, ovf);
        end
        rst = 1'b0;
        send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || $signed(dp) !== 70 || beats !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_result: out_valid=%b dp=%0d beats=%0d, required 1/70/1", out_valid, $signed(dp), beats);
        end
        drain();
    endtask

    task automatic test_random();
        int nb;
        rdy_rand = 1'b1;
        for (int v = 0; v < 200; v++) begin
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                send_beat($urandom, $urandom, b == nb - 1);
            end
        end
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid_vector();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dotproduct_stream.md
# dotproduct_stream

Streaming, pipelined signed dot-product engine: the sequential successor to the combinational `DotProduct` lane array. It accepts vectors of arbitrary length as a sequence of N-lane beats over a valid/ready handshake. It accumulates the per-beat lane sums and emits one result per vector with a beat count. It sits between the operand-fetch buffers and the activation/requantise stage of the NPU datapath.

## Interface
Parameters:
- `N`, 4: lanes per beat (≥1).
- `DATA_WIDTH`, 8: signed operand width.
- `ACC_WIDTH`, 24: signed accumulator/result width.
  - Requirement: `ACC_WIDTH ≥ 2*DATA_WIDTH + $clog2(N)`.
- `CNT_WIDTH`, 16: beat-counter width.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat can be accepted this cycle.
- `in_last`  in  1  offered beat is the final beat of its vector.
- `x`  in  N*DATA_WIDTH  packed signed operands; lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `w`  in  N*DATA_WIDTH  packed signed weights, same packing.
- `out_valid`  out  1  result held on `dp`/`beats`/`ovf`.
- `out_ready`  in  1  consumer accepts result.
- `dp`  out  ACC_WIDTH  signed dot product of the completed vector.
- `beats`  out  CNT_WIDTH  number of beats in that vector, saturating at all-ones.
- `ovf`  out  1  accumulator saturated during that vector (see Configuration).

## Operation
- **Transfer:** a beat is accepted on a rising edge where `in_valid && in_ready`. A result is consumed on a rising edge where `out_valid && out_ready`.
- **Stage S1 (reduce):** on accept, register `part = Σ x[i]*w[i]`.
  - Products are computed at full 2*DATA_WIDTH precision and summed exactly.
  - The sum is sign-extended to ACC_WIDTH.
  - `s1_valid` and `s1_last` are registered alongside it.
- **Stage S2 (accumulate), when `s1_valid`:**
  - `sum = (first ? 0 : acc) + part`.
  - `cnt = (first ? 0 : cnt) + 1`, saturating.
  - If `s1_last`: `dp <= sum`, `beats <= cnt`, `ovf <= sticky flag`, `out_valid <= 1`, and `first <= 1`.
  - Otherwise: `acc <= sum` and `first <= 0`.
- **Stall:** `stall = s1_valid && s1_last && out_valid && !out_ready`.
  - While stalled, S1 and S2 hold all state.
- **Input ready:** `in_ready = !rst && !stall`.
- **Output clear:** `out_valid` clears on consume unless a new result loads in the same edge. A new result has priority, so a consume and a load on the same edge produce back-to-back results.
- **Vector contents:** beats of one vector are contiguous. `in_last` on a beat closes the vector, so a 1-beat vector is legal.
- **Reset:** clears `out_valid`, `s1_valid`, `dp`, `beats`, `ovf`, `acc` and `cnt` to 0, and sets `first` to 1. A partially accumulated vector is discarded and produces no output.
- **No-input idle cycles:** these do not disturb accumulation.

## Timing
- Reset values: `in_ready=0` during reset, then 1. `out_valid=0`, `dp=0`, `beats=0`, `ovf=0`.
- Latency: a last beat accepted at edge k gives `out_valid=1` after edge k+1, i.e. visible in the cycle after the next edge.
- Throughput: 1 beat/cycle sustained when `out_ready` is held 1, including consecutive single-beat vectors.
- Outputs are stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_ready`; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `DOTPRODUCT_SAT_EN` defined:
  - S2 add is evaluated at ACC_WIDTH+1 bits and clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - Any clamp sets the vector's sticky flag, reported on `ovf` with the result and cleared at the next vector start.
- Not defined:
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - `ovf` is constant 0.

## Test plan
Defaults are N=4, DATA_WIDTH=8, ACC_WIDTH=24 unless stated.
1. **Single beat:** x={1,2,3,4}, w={5,6,7,8}, `in_last=1`, `out_ready=1` → `dp=70`, `beats=1`, `ovf=0`; `out_valid` high exactly one cycle, after the second edge following acceptance.
2. **Multi-beat:** 3 beats, all lanes x=w=−128, last on beat 3 → `dp=196608`, `beats=3`; no `out_valid` after beats 1–2.
3. **Backpressure:** vector A (test 1 values) then vector B (x={−1,−1,−1,−1}, w={2,2,2,2}) back-to-back with `out_ready=0` →
   - A held with `dp=70`;
   - `in_ready` falls once B's last reaches S1;
   - raise `out_ready` → A consumed, then `dp=−8`, `beats=1` next cycle;
   - no beat lost or duplicated.
4. **Saturation:** 128 beats of lanes x=w=−128 (65536 each; true sum 8388608) →
   - with `DOTPRODUCT_SAT_EN`: `dp=8388607`, `ovf=1`, `beats=128`;
   - without it: `dp=−8388608`, `ovf=0`.
5. **Reset mid-vector:** 2 non-last beats, `rst` for 1 cycle, then test-1 beat with last → single result `dp=70`, `beats=1`; all outputs 0 during reset.
6. **Random regression:** 200 random vectors of 1–8 beats with random `in_valid`/`out_ready` gaps → every result matches a reference model in order.
